// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } state_e;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int CNT_W     = 16;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to ptr.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       valid,
    output logic       sel
);
    assign valid = |req;
    assign sel   = (&req) ? ptr : req[REQ_DATA];
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requesters onto one memory port,
// one transaction outstanding, with a response timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_i,
    input  logic [2*ADDR_W-1:0] addr_i,
    input  logic [2*DATA_W-1:0] wdata_i,
    input  logic [1:0]          we_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic                mem_we_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                timeout_o,
    output logic                dbg_state_o,
    output logic                dbg_rr_ptr_o
);
    // Handshake: a requester raises req_i[k] and holds addr/wdata/we until
    // gnt_o[k]; the memory accepts in any cycle with mem_req_o & mem_gnt_i,
    // and answers later with a one-cycle mem_rvalid_i that is forwarded as
    // rvalid_o[owner] in the same cycle.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             pick_valid, pick_sel;
    logic             unused_inputs;

    assign unused_inputs = ^{wdata_i[DATA_W-1:0], we_i[REQ_FETCH]};

    rr_pick2 u_pick (
        .req   (req_i),
        .ptr   (rr_q),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        gnt_o       = 2'b00;
        rvalid_o    = 2'b00;
        rdata_o     = '0;
        err_o       = 1'b0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        // Reset gating keeps every combinational output quiet while rst is high.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    mem_req_o = pick_valid;
                    if (pick_valid) begin
                        mem_addr_o  = pick_sel ? addr_i[ADDR_W +: ADDR_W] : addr_i[0 +: ADDR_W];
                        mem_wdata_o = pick_sel ? wdata_i[DATA_W +: DATA_W] : '0;
                        mem_we_o    = pick_sel & we_i[REQ_DATA];
                        if (mem_gnt_i) begin
                            gnt_o[pick_sel] = 1'b1;
                            owner_d         = pick_sel;
                            rr_d            = ~pick_sel;
                            cnt_d           = '0;
                            state_d         = WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    cnt_d = (cnt_q == TMO_MAX) ? cnt_q : cnt_q + 1'b1;
                    if (mem_rvalid_i) begin
                        rvalid_o[owner_q] = 1'b1;
                        rdata_o           = mem_rdata_i;
                        state_d           = IDLE;
                    end else if (cnt_q >= TMO_LAST) begin
                        rvalid_o[owner_q] = 1'b1;
                        err_o             = 1'b1;
                        tmo_d             = 1'b1;
                        state_d           = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign timeout_o    = tmo_q & ~rst;
    assign dbg_state_o  = (state_q == WAIT_RSP) & ~rst;
    assign dbg_rr_ptr_o = rr_q & ~rst;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: selection table, directed
// multi-cycle sequences, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_i, we_i;
    logic [2*AW-1:0] addr_i;
    logic [2*DW-1:0] wdata_i;
    logic [1:0]     gnt_o, rvalid_o;
    logic [DW-1:0]  rdata_o;
    logic           err_o, mem_req_o, mem_we_o;
    logic [AW-1:0]  mem_addr_o;
    logic [DW-1:0]  mem_wdata_o;
    logic           mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0]  mem_rdata_i;
    logic           timeout_o, dbg_state_o, dbg_rr_ptr_o;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .we_i(we_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .timeout_o(timeout_o), .dbg_state_o(dbg_state_o), .dbg_rr_ptr_o(dbg_rr_ptr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change right after a falling edge; checks run #1 later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_i = 2'b00; we_i = 2'b00; addr_i = '0; wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        idle_inputs();
        cyc();
        rst = 1'b0;
    endtask

    task automatic prime_rr();
        req_i = 2'b01; mem_gnt_i = 1'b1;
        cyc();
        req_i = 2'b00; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        cyc();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, gnt_o, 0);
        chk({tag, "_rvalid"}, rvalid_o, 0);
        chk({tag, "_rdata"}, rdata_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_mem_req"}, mem_req_o, 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_mem_we"}, mem_we_o, 0);
        chk({tag, "_timeout"}, timeout_o, 0);
        chk({tag, "_state"}, dbg_state_o, 0);
        chk({tag, "_rr"}, dbg_rr_ptr_o, 0);
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] we;
        logic       gnt;
        logic       prime;
        logic       exp_req;
        logic [1:0] exp_gnt;
        logic       exp_sel;
    } vec_t;

    localparam logic [AW-1:0] A0 = 32'h0000_1000;
    localparam logic [AW-1:0] A1 = 32'h0000_2000;
    localparam logic [DW-1:0] W1 = 32'hA5A5_0001;

    vec_t vecs[10];

    // Random-phase model: transaction-level view of the arbiter.
    logic [1:0]    r_pend;
    logic [AW-1:0] r_addr[2];
    logic [DW-1:0] r_wdata[2];
    logic [1:0]    r_we;
    bit            m_busy, m_owner, m_we, m_tmo;
    int            m_last, m_age, mem_cd;

    initial begin
        rst = 1'b1;
        idle_inputs();
        req_i = 2'b11; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        cyc(); cyc();
        #1 chk_all_zero("reset");
        cyc();
        rst_pulse();

        // Selection table: {req, we, mem_gnt, prime rr, exp mem_req, exp gnt, exp sel}
        vecs[0] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[1] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[2] = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[3] = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1};
        vecs[4] = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1};
        vecs[5] = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[6] = '{2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1};
        vecs[7] = '{2'b11, 2'b10, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1};
        vecs[8] = '{2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1};
        vecs[9] = '{2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rst_pulse();
            if (vecs[i].prime) prime_rr();
            #1 chk("tbl_rr", dbg_rr_ptr_o, vecs[i].prime);
            req_i = vecs[i].req; we_i = vecs[i].we; mem_gnt_i = vecs[i].gnt;
            addr_i = {A1, A0}; wdata_i = {W1, 32'hFFFF_FFFF};
            #1;
            chk("tbl_mem_req", mem_req_o, vecs[i].exp_req);
            chk("tbl_gnt", gnt_o, vecs[i].exp_gnt);
            if (vecs[i].exp_req) begin
                chk("tbl_addr", mem_addr_o, vecs[i].exp_sel ? A1 : A0);
                chk("tbl_we", mem_we_o, vecs[i].exp_sel & vecs[i].we[1]);
                if (vecs[i].exp_sel) chk("tbl_wdata", mem_wdata_o, W1);
            end
            cyc();
        end

        // Single fetch, response two cycles after the grant.
        rst_pulse();
        req_i = 2'b01; addr_i = {32'h0, 32'h0000_0100}; mem_gnt_i = 1'b1;
        #1 chk("s1_gnt", gnt_o, 2'b01); chk("s1_addr", mem_addr_o, 32'h100); chk("s1_we", mem_we_o, 0);
        cyc();
        req_i = 2'b00; mem_gnt_i = 1'b0;
        #1 chk("s1_wait_rv", rvalid_o, 0); chk("s1_wait_state", dbg_state_o, 1); chk("s1_wait_req", mem_req_o, 0);
        cyc();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        #1 chk("s1_rvalid", rvalid_o, 2'b01); chk("s1_rdata", rdata_o, 32'hDEAD_BEEF); chk("s1_err", err_o, 0);
        cyc();
        mem_rvalid_i = 1'b0;
        #1 chk("s1_rr", dbg_rr_ptr_o, 1); chk("s1_idle", dbg_state_o, 0); chk("s1_rdata_idle", rdata_o, 0);
        cyc();

        // Both requesters held: grants alternate 0,1,0,1.
        rst_pulse();
        req_i = 2'b11; addr_i = {A1, A0};
        for (int i = 0; i < 4; i++) begin
            mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
            #1 chk("rr_gnt", gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10); chk("rr_not_both", gnt_o == 2'b11, 0);
            cyc();
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = DW'(i);
            #1 chk("rr_rvalid", rvalid_o, (i % 2 == 0) ? 2'b01 : 2'b10); chk("rr_wait_gnt", gnt_o, 0);
            chk("rr_wait_req", mem_req_o, 0);
            cyc();
        end
        mem_rvalid_i = 1'b0;

        // Data write stalled by the memory for three cycles.
        rst_pulse();
        req_i = 2'b10; we_i = 2'b10; addr_i = {32'h0000_0200, 32'h0}; wdata_i = {32'h1234_5678, 32'h0};
        for (int c = 0; c < 4; c++) begin
            mem_gnt_i = (c == 3);
            #1 chk("wr_mem_req", mem_req_o, 1); chk("wr_gnt", gnt_o, (c == 3) ? 2'b10 : 2'b00);
            chk("wr_we", mem_we_o, 1); chk("wr_wdata", mem_wdata_o, 32'h1234_5678);
            cyc();
        end
        req_i = 2'b00; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        #1 chk("wr_rvalid", rvalid_o, 2'b10); chk("wr_err", err_o, 0);
        cyc();
        mem_rvalid_i = 1'b0;

        // Memory never answers: error response four cycles after the grant.
        rst_pulse();
        req_i = 2'b01; mem_gnt_i = 1'b1;
        #1 chk("to_gnt", gnt_o, 2'b01);
        cyc();
        req_i = 2'b00; mem_gnt_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            if (c < 4) begin
                chk("to_early_rv", rvalid_o, 0); chk("to_early_flag", timeout_o, 0);
            end else begin
                chk("to_rvalid", rvalid_o, 2'b01); chk("to_err", err_o, 1); chk("to_rdata", rdata_o, 0);
            end
            cyc();
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0BAD;
        #1 chk("to_flag", timeout_o, 1); chk("to_late_rv", rvalid_o, 0);
        chk("to_late_rdata", rdata_o, 0); chk("to_late_err", err_o, 0); chk("to_late_state", dbg_state_o, 0);
        cyc();
        mem_rvalid_i = 1'b0;
        #1 chk("to_sticky", timeout_o, 1);
        cyc();

        // Reset in the middle of a wait abandons the transaction.
        rst_pulse();
        req_i = 2'b01; mem_gnt_i = 1'b1;
        cyc();
        req_i = 2'b00; mem_gnt_i = 1'b0;
        cyc();
        rst = 1'b1; req_i = 2'b11; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        #1 chk_all_zero("mid_rst");
        cyc();
        rst = 1'b0; req_i = 2'b10; we_i = 2'b00; mem_gnt_i = 1'b1;
        #1 chk("post_rst_gnt", gnt_o, 2'b10); chk("post_rst_rv", rvalid_o, 0); chk("post_rst_tmo", timeout_o, 0);
        cyc();
        req_i = 2'b00; mem_gnt_i = 1'b0;
        #1 chk("post_rst_wait", dbg_state_o, 1);
        cyc();
        mem_rvalid_i = 1'b0;

        // Response lands in the very cycle the timeout would fire.
        rst_pulse();
        req_i = 2'b01; mem_gnt_i = 1'b1;
        cyc();
        req_i = 2'b00; mem_gnt_i = 1'b0;
        cyc(); cyc(); cyc();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_55AA;
        #1 chk("tie_rvalid", rvalid_o, 2'b01); chk("tie_err", err_o, 0); chk("tie_rdata", rdata_o, 32'h55AA);
        cyc();
        mem_rvalid_i = 1'b0;
        #1 chk("tie_tmo", timeout_o, 0); chk("tie_idle", dbg_state_o, 0);
        cyc();

        // Random traffic against the transaction-level model.
        rst_pulse();
        m_busy = 0; m_owner = 0; m_we = 0; m_tmo = 0; m_last = 1; m_age = 0; mem_cd = -1;
        r_pend = 2'b00; r_we = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            bit rv, do_rst, g, done, tmo_now, e_sel, e_req, e_err, chk_rd;
            logic [1:0]    e_gnt, e_rv;
            logic [DW-1:0] e_rd;
            for (int k = 0; k < 2; k++) begin
                if (!r_pend[k] && $urandom_range(0, 2) == 0) begin
                    r_pend[k] = 1'b1; r_addr[k] = $urandom; r_wdata[k] = $urandom; r_we[k] = 1'($urandom_range(0, 1));
                end
            end
            if (mem_cd > 0) mem_cd--;
            rv = (mem_cd == 0);
            if (rv) mem_cd = -1;
            else if (!m_busy && $urandom_range(0, 9) == 0) rv = 1;
            do_rst = ($urandom_range(0, 149) == 0);
            rst = do_rst; req_i = r_pend; we_i = r_we;
            addr_i = {r_addr[1], r_addr[0]}; wdata_i = {r_wdata[1], r_wdata[0]};
            mem_gnt_i = ($urandom_range(0, 3) != 0); mem_rvalid_i = rv; mem_rdata_i = $urandom;

            e_gnt = 0; e_rv = 0; e_rd = 0; e_err = 0; e_req = 0; e_sel = 0; chk_rd = 1;
            g = 0; done = 0; tmo_now = 0;
            if (!do_rst) begin
                if (!m_busy) begin
                    e_req = r_pend[0] | r_pend[1];
                    e_sel = (r_pend[0] && r_pend[1]) ? (m_last == 0) : r_pend[1];
                    if (e_req && mem_gnt_i) begin
                        g = 1; e_gnt = e_sel ? 2'b10 : 2'b01;
                    end
                end else if (rv) begin
                    e_rv = m_owner ? 2'b10 : 2'b01; e_rd = mem_rdata_i; chk_rd = !m_we; done = 1;
                end else if (m_age >= TMO) begin
                    e_rv = m_owner ? 2'b10 : 2'b01; e_err = 1; done = 1; tmo_now = 1;
                end
            end
            #1;
            chk("rnd_gnt", gnt_o, e_gnt);
            chk("rnd_not_both", gnt_o == 2'b11, 0);
            chk("rnd_rvalid", rvalid_o, e_rv);
            chk("rnd_err", err_o, e_err);
            if (chk_rd) chk("rnd_rdata", rdata_o, e_rd);
            chk("rnd_mem_req", mem_req_o, e_req);
            chk("rnd_timeout", timeout_o, !do_rst && m_tmo);
            chk("rnd_state", dbg_state_o, !do_rst && m_busy);
            chk("rnd_rr", dbg_rr_ptr_o, !do_rst && (m_last == 0));
            if (e_req) begin
                chk("rnd_addr", mem_addr_o, r_addr[e_sel]);
                chk("rnd_we", mem_we_o, e_sel && r_we[1]);
                if (e_sel) chk("rnd_wdata", mem_wdata_o, r_wdata[1]);
            end

            if (do_rst) begin
                m_busy = 0; m_last = 1; m_tmo = 0; mem_cd = -1;
            end else if (g) begin
                m_busy = 1; m_owner = e_sel; m_last = int'(e_sel); m_age = 1;
                m_we = e_sel && r_we[1]; r_pend[e_sel] = 1'b0; mem_cd = $urandom_range(1, 6);
            end else if (done) begin
                m_busy = 0;
                if (tmo_now) m_tmo = 1;
            end else if (m_busy) begin
                m_age++;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all ports.
REQ-002 Parameter DATA_W, default 32: data width of all ports.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles the block waits for a memory response, range 1..65535.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_i  in  2  per-requester request; [0] = instruction fetch, [1] = data access.
REQ-007 addr_i  in  2xADDR_W  per-requester address.
REQ-008 wdata_i  in  2xDATA_W  per-requester write data; [0] is unused.
REQ-009 we_i  in  2  per-requester write enable; we_i[0] is ignored and treated as 0.
REQ-010 gnt_o  out  2  per-requester grant: the request is accepted this cycle.
REQ-011 rvalid_o  out  2  per-requester response-valid pulse.
REQ-012 rdata_o  out  DATA_W  response data, shared by both requesters and qualified by rvalid_o.
REQ-013 err_o  out  1  response error, qualified by rvalid_o.
REQ-014 mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o  out  1/ADDR_W/DATA_W/1  the shared memory request.
REQ-015 mem_gnt_i  in  1  memory accepts mem_req_o this cycle.
REQ-016 mem_rvalid_i, mem_rdata_i  in  1/DATA_W  memory response, at least 1 cycle after acceptance.
REQ-017 timeout_o  out  1  sticky flag: a timeout has occurred.

Function
REQ-018 FSM states: IDLE and WAIT_RSP; at most one memory transaction outstanding.
REQ-019 In IDLE, mem_req_o shall equal req_i[0] | req_i[1], and the mem address, data and write-enable outputs shall come combinationally from the selected requester.
REQ-020 Selection: if only one requester is active, select it; if both are active, select the one pointed to by the round-robin pointer rr_ptr.
REQ-021 Grant: gnt_o[k] = IDLE & selected==k & mem_gnt_i; at most one grant bit shall be high in any cycle.
REQ-022 On a grant:
- latch owner = k;
- set rr_ptr = 1-k;
- clear the wait counter;
- move to WAIT_RSP on the next cycle.
REQ-023 If mem_gnt_i=0, stay in IDLE with no grant and leave rr_ptr unchanged; the requester holds req, addr, wdata and we stable until it is granted.
REQ-024 In WAIT_RSP:
- mem_req_o = 0 and gnt_o = 0;
- the wait counter increments by 1 each cycle and saturates at TIMEOUT.
REQ-025 On mem_rvalid_i in WAIT_RSP:
- rvalid_o[owner] = 1 and rdata_o = mem_rdata_i in the same cycle (0-cycle combinational path);
- err_o = 0;
- return to IDLE; the next grant is possible at the earliest 1 cycle later.
REQ-026 Write transactions also complete through mem_rvalid_i; rdata_o is don't-care for a write.
REQ-027 When the wait counter reaches TIMEOUT without mem_rvalid_i:
- pulse rvalid_o[owner] = 1 with err_o = 1 and rdata_o = 0;
- set timeout_o;
- return to IDLE.
If mem_rvalid_i arrives in that same cycle, the normal response (REQ-025) wins.
REQ-028 mem_rvalid_i received in IDLE, including a late response after a timeout, shall be discarded with no output effect.
REQ-029 When no rvalid_o bit is high, rdata_o and err_o shall be 0.
REQ-030 timeout_o shall be cleared only by rst.

Reset
REQ-031 While rst=1:
- state = IDLE, rr_ptr = 0, owner = 0, wait counter = 0, timeout_o = 0;
- all outputs shall be 0.
REQ-032 rst asserted during WAIT_RSP shall abandon the transaction with no rvalid_o pulse; a mem_rvalid_i arriving afterwards is discarded per REQ-028.

Structure
REQ-033 Shared package mem_arb_pkg shall hold:
- the state enum (IDLE, WAIT_RSP);
- the requester index constants REQ_FETCH=0 and REQ_DATA=1;
- the wait-counter width constant of 16 bits.
REQ-034 The two-way round-robin selection shall be one combinational sub-module, rr_pick2, with inputs req[1:0] and ptr and outputs valid and sel.
REQ-035 The rest of the block shall be one module: FSM, owner register, rr_ptr, wait counter and response routing.

Verification
REQ-036 Scenario: req_i=01, addr 0x100, mem_gnt_i=1, rvalid 2 cycles later with 0xDEADBEEF -> gnt_o=01 in cycle 0; rvalid_o=01 with rdata 0xDEADBEEF in cycle 2; rr_ptr=1.
REQ-037 Scenario: req_i=11 held for 4 transactions, each with a 1-cycle response -> grant order 0,1,0,1; no cycle has both gnt_o bits set.
REQ-038 Scenario: data write (req_i=10, we=1, wdata 0x12345678), mem_gnt_i=0 for 3 cycles then 1 -> mem_req_o is high for all 4 cycles; gnt_o[1] goes high only in cycle 3; mem_we_o=1 and mem_wdata_o=0x12345678.
REQ-039 Scenario: TIMEOUT=4, memory never responds -> rvalid_o[owner]=1 with err_o=1 exactly 4 cycles after the grant; timeout_o=1; a late mem_rvalid_i is ignored.
REQ-040 Scenario: rst pulsed 1 cycle while in WAIT_RSP -> all outputs 0, state IDLE, no rvalid_o pulse; a new request is granted on the first cycle after rst drops.
REQ-041 Scenario: mem_rvalid_i arrives in the same cycle the timeout is reached -> normal response with err_o=0 and timeout_o unchanged.
